atan_arb: RTL and testbench

ATAN_ARB -- requirements
Module: atan_arb

---
 rtl/atan_arb_if.sv | 34 +++
 rtl/atan_arb.sv | 137 +++++++++++++
 tb/tb_atan_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atan_arb_if.sv
// Handshake and data bundle between the requesters, the shared AtanPoly pipeline and the result sinks.
interface atan_arb_if #(
    parameter int unsigned W_IN  = 8,
    parameter int unsigned W_OUT = 16
);
    logic             req0_val;
    logic             req1_val;
    logic [W_IN-1:0]  req0_data;
    logic [W_IN-1:0]  req1_data;
    logic             req0_rdy;
    logic             req1_rdy;
    logic             ap_val_i;
    logic [W_IN-1:0]  ap_data_i;
    logic             ap_val_o;
    logic [W_OUT-1:0] ap_data_o;
    logic             res0_val;
    logic             res1_val;
    logic [W_OUT-1:0] res0_data;
    logic [W_OUT-1:0] res1_data;

    // Environment side: requesters, AtanPoly result port, result sinks.
    modport master (
        output req0_val, req1_val, req0_data, req1_data, ap_val_o, ap_data_o,
        input  req0_rdy, req1_rdy, ap_val_i, ap_data_i,
        input  res0_val, res1_val, res0_data, res1_data
    );

    // Arbiter side.
    modport slave (
        input  req0_val, req1_val, req0_data, req1_data, ap_val_o, ap_data_o,
        output req0_rdy, req1_rdy, ap_val_i, ap_data_i,
        output res0_val, res1_val, res0_data, res1_data
    );
endinterface

// File: rtl/atan_arb.sv
// Two-requester round-robin front end for a shared AtanPoly pipeline; a tag FIFO routes
// each in-order result back to the requester that issued its operand.
module atan_arb #(
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned W_IN         = 8,
    parameter int unsigned W_OUT        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    atan_arb_if.slave                     bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          busy,
    output logic                          err_unf
);
    localparam int unsigned AW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            gnt_ok;
    logic            last_gnt;
    logic            sel;
    logic            rdy0;
    logic            rdy1;
    logic            push;
    logic            pop;
    logic            unf;
    logic            tag_rd;
    logic [W_IN-1:0] gnt_data;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            tag_mem [MAX_INFLIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are only issued while running with en held and pipeline credit left.
    always_comb begin
        state_nxt = state;
        gnt_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                gnt_ok = en && (inflight < FULL);
                if (!en) begin
                    state_nxt = (inflight == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie the requester that did not win last time gets the slot.
    assign sel      = (bus.req0_val && bus.req1_val) ? ~last_gnt : bus.req1_val;
    assign rdy0     = gnt_ok && bus.req0_val && !sel;
    assign rdy1     = gnt_ok && bus.req1_val && sel;
    assign push     = rdy0 || rdy1;
    assign gnt_data = sel ? bus.req1_data : bus.req0_data;
    assign pop      = bus.ap_val_o && (inflight != '0);
    assign unf      = bus.ap_val_o && (inflight == '0);
    assign tag_rd   = tag_mem[rptr];

    assign bus.req0_rdy = rdy0;
    assign bus.req1_rdy = rdy1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt      <= 1'b1;
            wptr          <= '0;
            rptr          <= '0;
            inflight      <= '0;
            busy          <= 1'b0;
            err_unf       <= 1'b0;
            bus.ap_val_i  <= 1'b0;
            bus.ap_data_i <= '0;
            bus.res0_val  <= 1'b0;
            bus.res1_val  <= 1'b0;
            bus.res0_data <= '0;
            bus.res1_data <= '0;
        end else begin
            busy         <= (state_nxt != IDLE);
            bus.ap_val_i <= push;
            bus.res0_val <= pop && !tag_rd;
            bus.res1_val <= pop && tag_rd;
            if (push) begin
                last_gnt      <= sel;
                wptr          <= wptr + AW'(1);
                bus.ap_data_i <= gnt_data;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
                if (tag_rd) begin
                    bus.res1_data <= W_OUT'(bus.ap_data_o);
                end else begin
                    bus.res0_data <= W_OUT'(bus.ap_data_o);
                end
            end
            if (push && !pop) begin
                inflight <= inflight + CW'(1);
            end else if (pop && !push) begin
                inflight <= inflight - CW'(1);
            end
            if (unf) begin
                err_unf <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wptr] <= sel;
        end
    end
endmodule

// File: tb/tb_atan_arb.sv
// Directed bench for atan_arb: arbitration table, drain, underflow, reset and streaming checks
// against a bench-side AtanPoly latency model.
module tb_atan_arb;
    localparam int unsigned MAXI = 16;
    localparam int unsigned CW   = $clog2(MAXI) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] inflight;
    logic          busy;
    logic          err_unf;

    atan_arb_if #(.W_IN(8), .W_OUT(16)) bus ();

    atan_arb #(.MAX_INFLIGHT(MAXI), .W_IN(8), .W_OUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .inflight (inflight),
        .busy     (busy),
        .err_unf  (err_unf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_f(input logic [7:0] x);
        return {x ^ 8'hA5, ~x};
    endfunction

    // AtanPoly stand-in: fixed-latency in-order pipeline, or manual drive of its result port.
    bit          man_mode;
    logic        man_val;
    logic [15:0] man_data;
    int          lat_m;
    int          mcyc;
    int          mq_t[$];
    logic [15:0] mq_d[$];

    initial begin
        bus.ap_val_o  = 1'b0;
        bus.ap_data_o = '0;
        mcyc = 0;
        forever begin
            @(negedge clk);
            #1;
            mcyc++;
            if (man_mode || rst) begin
                mq_t.delete();
                mq_d.delete();
                bus.ap_val_o  = man_mode ? man_val : 1'b0;
                bus.ap_data_o = man_data;
            end else begin
                if (bus.ap_val_i) begin
                    mq_t.push_back(mcyc + lat_m);
                    mq_d.push_back(ref_f(bus.ap_data_i));
                end
                if (mq_t.size() > 0 && mq_t[0] <= mcyc) begin
                    bus.ap_val_o  = 1'b1;
                    bus.ap_data_o = mq_d.pop_front();
                    void'(mq_t.pop_front());
                end else begin
                    bus.ap_val_o = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        en           = 1'b0;
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        man_val      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] src0[$];
    logic [7:0] src1[$];

    // Streams src0/src1 through the DUT, predicting grants, credit and routing independently.
    task automatic run_stream(input int lat, input bit rand_v, input int budget, output int peak);
        int          i0 = 0;
        int          i1 = 0;
        int          g0 = 0;
        int          g1 = 0;
        int          binf = 0;
        int          n0 = src0.size();
        int          n1 = src1.size();
        bit          prev = 1'b1;
        bit          v0, v1, win, exp_any;
        logic [15:0] eq0[$];
        logic [15:0] eq1[$];
        bit          ord[$];
        man_mode = 1'b0;
        lat_m    = lat;
        peak     = 0;
        for (int c = 0; c < budget && (g0 < n0 || g1 < n1); c++) begin
            @(negedge clk);
            en = 1'b1;
            v0 = (i0 < n0) && (!rand_v || ($urandom_range(0, 1) == 1));
            v1 = (i1 < n1) && (!rand_v || ($urandom_range(0, 1) == 1));
            bus.req0_val  = v0;
            bus.req1_val  = v1;
            bus.req0_data = (i0 < n0) ? src0[i0] : 8'h00;
            bus.req1_data = (i1 < n1) ? src1[i1] : 8'h00;
            #2;
            check("stream inflight", 32'(inflight), 32'(binf));
            if (int'(inflight) > peak) peak = int'(inflight);
            if (bus.res0_val) begin
                if (ord.size() == 0 || eq0.size() == 0) begin
                    check("res0 unexpected", 1, 0);
                end else begin
                    check("res0 order", 32'(ord.pop_front()), 0);
                    check("res0 data", 32'(bus.res0_data), 32'(eq0.pop_front()));
                end
                g0++;
            end
            if (bus.res1_val) begin
                if (ord.size() == 0 || eq1.size() == 0) begin
                    check("res1 unexpected", 1, 0);
                end else begin
                    check("res1 order", 32'(ord.pop_front()), 1);
                    check("res1 data", 32'(bus.res1_data), 32'(eq1.pop_front()));
                end
                g1++;
            end
            exp_any = (v0 || v1) && (c > 0) && (binf < int'(MAXI));
            win     = (v0 && v1) ? ~prev : v1;
            check("stream rdy0", 32'(bus.req0_rdy), 32'(exp_any && !win));
            check("stream rdy1", 32'(bus.req1_rdy), 32'(exp_any && win));
            if (bus.ap_val_o && binf > 0) binf--;
            if (exp_any) begin
                binf++;
                prev = win;
                ord.push_back(win);
                if (win) begin
                    eq1.push_back(ref_f(src1[i1]));
                    i1++;
                end else begin
                    eq0.push_back(ref_f(src0[i0]));
                    i0++;
                end
            end
        end
        check("res0 count", 32'(g0), 32'(n0));
        check("res1 count", 32'(g1), 32'(n1));
        @(negedge clk);
        en           = 1'b0;
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
    endtask

    typedef struct {
        logic       en, v0, v1;
        logic [7:0] d0, d1;
        logic       r0, r1, busy;
        int         inf;
        logic       apv;
        logic [7:0] apd;
    } vec_t;

    vec_t tbl[12];
    bit   drain_tag[8];
    int   pk;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h80, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h81, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h12, 8'h82, 1'b0, 1'b1, 1'b1, 1, 1'b1, 8'h11};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h13, 8'h83, 1'b1, 1'b0, 1'b1, 2, 1'b1, 8'h82};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h14, 8'h84, 1'b0, 1'b1, 1'b1, 3, 1'b1, 8'h13};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h15, 8'h85, 1'b0, 1'b1, 1'b1, 4, 1'b1, 8'h84};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h16, 8'h86, 1'b1, 1'b0, 1'b1, 5, 1'b1, 8'h85};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h17, 8'h87, 1'b0, 1'b0, 1'b1, 6, 1'b1, 8'h16};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h18, 8'h88, 1'b1, 1'b0, 1'b1, 6, 1'b0, 8'h16};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h19, 8'h89, 1'b0, 1'b1, 1'b1, 7, 1'b1, 8'h18};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h1A, 8'h8A, 1'b0, 1'b0, 1'b1, 8, 1'b1, 8'h89};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h1B, 8'h8B, 1'b0, 1'b0, 1'b1, 8, 1'b0, 8'h89};
        drain_tag = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst           = 1'b1;
        en            = 1'b0;
        bus.req0_val  = 1'b0;
        bus.req1_val  = 1'b0;
        bus.req0_data = '0;
        bus.req1_data = '0;
        man_mode      = 1'b1;
        man_val       = 1'b0;
        man_data      = '0;
        lat_m         = 5;

        repeat (2) @(negedge clk);
        #2;
        check("reset inflight", 32'(inflight), 0);
        check("reset busy", 32'(busy), 0);
        check("reset err_unf", 32'(err_unf), 0);
        check("reset ap_val_i", 32'(bus.ap_val_i), 0);
        check("reset ap_data_i", 32'(bus.ap_data_i), 0);
        check("reset res_val", 32'({bus.res0_val, bus.res1_val}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Arbitration and credit table with the result port held idle.
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            en            = tbl[r].en;
            bus.req0_val  = tbl[r].v0;
            bus.req1_val  = tbl[r].v1;
            bus.req0_data = tbl[r].d0;
            bus.req1_data = tbl[r].d1;
            #2;
            check($sformatf("row%0d rdy0", r), 32'(bus.req0_rdy), 32'(tbl[r].r0));
            check($sformatf("row%0d rdy1", r), 32'(bus.req1_rdy), 32'(tbl[r].r1));
            check($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
            check($sformatf("row%0d inflight", r), 32'(inflight), 32'(tbl[r].inf));
            check($sformatf("row%0d ap_val_i", r), 32'(bus.ap_val_i), 32'(tbl[r].apv));
            check($sformatf("row%0d ap_data_i", r), 32'(bus.ap_data_i), 32'(tbl[r].apd));
        end

        // Drain: eight results route by issue order; no grants while draining.
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            man_val  = (k < 8);
            man_data = 16'hC000 + 16'(k);
            #2;
            check($sformatf("drain%0d rdy", k), 32'({bus.req0_rdy, bus.req1_rdy}), 0);
            check($sformatf("drain%0d busy", k), 32'(busy), 1);
            check($sformatf("drain%0d inflight", k), 32'(inflight), 32'(8 - k));
            if (k > 0) begin
                check($sformatf("drain%0d res0_val", k), 32'(bus.res0_val), 32'(!drain_tag[k-1]));
                check($sformatf("drain%0d res1_val", k), 32'(bus.res1_val), 32'(drain_tag[k-1]));
                if (drain_tag[k-1])
                    check($sformatf("drain%0d res1_data", k), 32'(bus.res1_data), 32'(16'hC000 + 16'(k - 1)));
                else
                    check($sformatf("drain%0d res0_data", k), 32'(bus.res0_data), 32'(16'hC000 + 16'(k - 1)));
            end
        end
        @(negedge clk);
        man_val      = 1'b0;
        en           = 1'b0;
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        #2;
        check("drained busy", 32'(busy), 0);
        check("drained res_val", 32'({bus.res0_val, bus.res1_val}), 0);
        check("hold res0_data", 32'(bus.res0_data), 32'h0000_C006);
        check("hold res1_data", 32'(bus.res1_data), 32'h0000_C007);
        check("drained err_unf", 32'(err_unf), 0);

        // Spurious result with nothing outstanding.
        @(negedge clk);
        man_val  = 1'b1;
        man_data = 16'hDEAD;
        @(negedge clk);
        man_val = 1'b0;
        #2;
        check("unf err_unf", 32'(err_unf), 1);
        check("unf res_val", 32'({bus.res0_val, bus.res1_val}), 0);
        check("unf inflight", 32'(inflight), 0);
        repeat (3) @(negedge clk);
        #2;
        check("unf sticky", 32'(err_unf), 1);
        do_reset();
        #2;
        check("unf cleared", 32'(err_unf), 0);

        // Single requester, latency 5.
        src0.delete();
        src1.delete();
        for (int i = 0; i < 16; i++) src0.push_back(8'h10 + 8'(i));
        do_reset();
        run_stream(5, 1'b0, 200, pk);
        check("solo peak<=6", 32'(pk <= 6), 1);

        // Both requesters continuously valid: strict alternation.
        src0.delete();
        src1.delete();
        for (int i = 0; i < 8; i++) begin
            src0.push_back(8'h20 + 8'(i));
            src1.push_back(8'h40 + 8'(i));
        end
        do_reset();
        run_stream(3, 1'b0, 200, pk);

        // Long latency saturates credit.
        src0.delete();
        src1.delete();
        for (int i = 0; i < 40; i++) src0.push_back(8'h60 + 8'(i));
        do_reset();
        run_stream(20, 1'b0, 400, pk);
        check("saturation peak", 32'(pk), 32'(MAXI));

        // Reset with five outstanding, then a late result counts as underflow.
        do_reset();
        man_mode      = 1'b1;
        man_val       = 1'b0;
        en            = 1'b1;
        bus.req0_val  = 1'b1;
        bus.req0_data = 8'h5C;
        repeat (6) @(negedge clk);
        #2;
        check("pre-reset inflight", 32'(inflight), 5);
        #1;
        rst = 1'b1;
        #1;
        check("async inflight", 32'(inflight), 0);
        check("async busy", 32'(busy), 0);
        check("async ap_val_i", 32'(bus.ap_val_i), 0);
        check("async ap_data_i", 32'(bus.ap_data_i), 0);
        check("async rdy", 32'({bus.req0_rdy, bus.req1_rdy}), 0);
        check("async res", 32'({bus.res0_val, bus.res1_val, bus.res0_data, bus.res1_data}), 0);
        check("async err_unf", 32'(err_unf), 0);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        en           = 1'b0;
        bus.req0_val = 1'b0;
        man_val      = 1'b1;
        man_data     = 16'h1234;
        @(negedge clk);
        man_val = 1'b0;
        #2;
        check("late result err_unf", 32'(err_unf), 1);
        check("late result res_val", 32'({bus.res0_val, bus.res1_val}), 0);

        // 1024 random vectors after a clean reset.
        src0.delete();
        src1.delete();
        for (int i = 0; i < 512; i++) begin
            src0.push_back(8'($urandom));
            src1.push_back(8'($urandom));
        end
        do_reset();
        run_stream(7, 1'b1, 6000, pk);
        check("random err_unf", 32'(err_unf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
